// File: rtl/lnn_decoder_pkg.sv
// Shared definitions for the linear-prediction residual codec (encoder and decoder).
package lnn_pkg;

    localparam int FRAME_LEN    = 96;
    localparam int SYMBOL_W     = 4;
    localparam int WEIGHT_W     = 3;
    localparam int DIVISOR      = 10;
    localparam int PRIME_FRAMES = 3;

    typedef logic [SYMBOL_W-1:0] symbol_t;
    typedef logic [WEIGHT_W-1:0] weight_t;

    // PRIME: raw samples fill the history; DECODE: residual + prediction.
    typedef enum logic {
        ST_PRIME  = 1'b0,
        ST_DECODE = 1'b1
    } lnn_state_t;

endpackage

// File: rtl/lnn_decoder_if.sv
// Symbol stream into and reconstructed samples out of the decoder.
interface lnn_decoder_if;
    import lnn_pkg::*;

    logic    in_valid;
    symbol_t in_symbol;
    logic    in_last;
    logic    out_valid;
    symbol_t out_symbol;
    logic    out_last;

    // Stream source / sample sink side.
    modport master (
        output in_valid, in_symbol, in_last,
        input  out_valid, out_symbol, out_last
    );

    // Decoder side.
    modport slave (
        input  in_valid, in_symbol, in_last,
        output out_valid, out_symbol, out_last
    );

endinterface

// File: rtl/lnn_decoder_predict.sv
// 3-tap weighted predictor shared by encoder and decoder so both sides
// compute bit-identical predictions: floor((w1*p1+w2*p2+w3*p3)/DIVISOR) mod 2^DATA_W.
module lnn_predict
    import lnn_pkg::*;
#(
    parameter int DATA_W = SYMBOL_W,
    parameter int COEF_W = WEIGHT_W
) (
    input  logic [COEF_W-1:0] w1,
    input  logic [COEF_W-1:0] w2,
    input  logic [COEF_W-1:0] w3,
    input  logic [DATA_W-1:0] p1,
    input  logic [DATA_W-1:0] p2,
    input  logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] pred
);

    localparam int PROD_W = COEF_W + DATA_W;
    localparam int SUM_W  = PROD_W + 2;

    logic [PROD_W-1:0] prod1;
    logic [PROD_W-1:0] prod2;
    logic [PROD_W-1:0] prod3;
    logic [SUM_W-1:0]  sum;

    // Quotient is kept only modulo 2^DATA_W; the wrap is undone by the
    // modular add on the decoder side.
    function automatic logic [DATA_W-1:0] div_trunc(input logic [SUM_W-1:0] s);
        logic [SUM_W-1:0] q;
        q = s / SUM_W'(DIVISOR);
        return q[DATA_W-1:0];
    endfunction

    // Weighted sum of the three history taps, then scaled prediction.
    always_comb begin
        prod1 = w1 * p1;
        prod2 = w2 * p2;
        prod3 = w3 * p3;
        sum   = SUM_W'(prod1) + SUM_W'(prod2) + SUM_W'(prod3);
        pred  = div_trunc(sum);
    end

endmodule

// File: rtl/lnn_decoder.sv
// Residual decoder: rebuilds samples as (residual + prediction) mod 16 using
// per-position history of the three previous frames. The first PRIME_FRAMES
// frames are raw samples that only fill the history.
module lnn_decoder
    import lnn_pkg::*;
#(
    parameter int FRAME_LEN    = lnn_pkg::FRAME_LEN,
    parameter int ADDR_W       = 10,
    parameter int PRIME_FRAMES = lnn_pkg::PRIME_FRAMES
) (
    input  logic                sys_clk,
    input  logic                sys_reset,
    input  logic                restart,
    lnn_decoder_if.slave        strm,
    output logic [ADDR_W-1:0]   rom_addr,
    input  weight_t             weight1,
    input  weight_t             weight2,
    input  weight_t             weight3,
    output logic                primed,
    output logic                sync_err
);

    localparam int POS_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FCNT_W = $clog2(PRIME_FRAMES + 1);
    localparam logic [POS_W-1:0]  LAST_POS   = POS_W'(FRAME_LEN - 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL  = FCNT_W'(PRIME_FRAMES);
    localparam logic [FCNT_W-1:0] FCNT_FINAL = FCNT_W'(PRIME_FRAMES - 1);

    // Modular sample reconstruction; wrap-around inverts the encoder's wrapped subtraction.
    function automatic symbol_t wrap_add(input symbol_t a, input symbol_t b);
        return a + b;
    endfunction

    lnn_state_t        state;
    lnn_state_t        state_nxt;
    logic [POS_W-1:0]  pos_p0;
    logic [POS_W-1:0]  pos_nxt;
    logic [FCNT_W-1:0] fcnt;
    logic [FCNT_W-1:0] fcnt_nxt;
    logic              sync_err_nxt;
    logic              accept;
    logic              at_last;

    logic              vld_p1;
    symbol_t           sym_p1;
    logic [POS_W-1:0]  pos_p1;
    logic              dec_p1;
    logic              commit_p1;

    symbol_t           hist1 [FRAME_LEN];
    symbol_t           hist2 [FRAME_LEN];
    symbol_t           hist3 [FRAME_LEN];
    symbol_t           hp1_p1;
    symbol_t           hp2_p1;
    symbol_t           hp3_p1;
    symbol_t           pred_p1;
    symbol_t           out_val_p1;

    logic              vld_p2;
    symbol_t           sym_p2;
    logic              last_p2;

    // restart has priority: a symbol presented alongside it is dropped.
    assign accept   = strm.in_valid && !restart;
    assign at_last  = (pos_p0 == LAST_POS);
    assign rom_addr = ADDR_W'(pos_p0);
    assign primed   = (state == ST_DECODE);

    // Next-state: mode, frame count, position counter and frame-sync error.
    always_comb begin
        state_nxt    = state;
        fcnt_nxt     = fcnt;
        pos_nxt      = pos_p0;
        sync_err_nxt = sync_err;
        if (restart) begin
            state_nxt    = ST_PRIME;
            fcnt_nxt     = '0;
            pos_nxt      = '0;
            sync_err_nxt = 1'b0;
        end else if (strm.in_valid) begin
            // An early in_last resynchronises the frame to position 0.
            if (strm.in_last || at_last) begin
                pos_nxt = '0;
            end else begin
                pos_nxt = pos_p0 + 1'b1;
            end
            if (strm.in_last != at_last) begin
                sync_err_nxt = 1'b1;
            end
            if (at_last && (fcnt != FCNT_FULL)) begin
                fcnt_nxt = fcnt + 1'b1;
            end
            case (state)
                ST_PRIME: begin
                    if (at_last && (fcnt == FCNT_FINAL)) begin
                        state_nxt = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_nxt = ST_DECODE;
                end
                default: begin
                    state_nxt = ST_PRIME;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state    <= ST_PRIME;
            fcnt     <= '0;
            pos_p0   <= '0;
            sync_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            fcnt     <= fcnt_nxt;
            pos_p0   <= pos_nxt;
            sync_err <= sync_err_nxt;
        end
    end

    // ---- stage 0 -> 1: capture accepted symbol; ROM presents weights next cycle ----

    // Stage-1 valid.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept;
        end
    end

    // Stage-1 data; the mode is captured with the symbol so the last priming
    // sample stays raw even though the state has already moved on.
    always_ff @(posedge sys_clk) begin
        if (accept) begin
            sym_p1 <= strm.in_symbol;
            pos_p1 <= pos_p0;
            dec_p1 <= (state == ST_DECODE);
        end
    end

    // ---- stage 1 -> 2: predict, reconstruct, register output and update history ----

    assign commit_p1 = vld_p1 && !restart;
    assign hp1_p1    = hist1[pos_p1];
    assign hp2_p1    = hist2[pos_p1];
    assign hp3_p1    = hist3[pos_p1];

    lnn_predict #(
        .DATA_W (SYMBOL_W),
        .COEF_W (WEIGHT_W)
    ) u_predict (
        .w1   (weight1),
        .w2   (weight2),
        .w3   (weight3),
        .p1   (hp1_p1),
        .p2   (hp2_p1),
        .p3   (hp3_p1),
        .pred (pred_p1)
    );

    assign out_val_p1 = dec_p1 ? wrap_add(sym_p1, pred_p1) : sym_p1;

    // Output register; an in-flight sample is discarded on restart.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            vld_p2  <= 1'b0;
            sym_p2  <= '0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= commit_p1;
            last_p2 <= commit_p1 && (pos_p1 == LAST_POS);
            if (commit_p1) begin
                sym_p2 <= out_val_p1;
            end
        end
    end

    // History shift for this position; consecutive accepts always hit different entries.
    always_ff @(posedge sys_clk) begin
        if (commit_p1) begin
            hist3[pos_p1] <= hp2_p1;
            hist2[pos_p1] <= hp1_p1;
            hist1[pos_p1] <= out_val_p1;
        end
    end

    assign strm.out_valid  = vld_p2;
    assign strm.out_symbol = sym_p2;
    assign strm.out_last   = last_p2;

endmodule

// File: tb/tb_lnn_decoder.sv
// Scoreboard bench for lnn_decoder: a frame-level encoder/decoder model
// generates residuals and expected samples; a monitor checks every output.
module tb_lnn_decoder;
    import lnn_pkg::*;

    localparam int FL     = 96;
    localparam int ADDR_W = 10;

    logic              sys_clk = 1'b0;
    logic              sys_reset;
    logic              restart;
    logic [ADDR_W-1:0] rom_addr;
    logic [2:0]        weight1;
    logic [2:0]        weight2;
    logic [2:0]        weight3;
    logic              primed;
    logic              sync_err;

    lnn_decoder_if bus ();

    lnn_decoder #(
        .FRAME_LEN    (FL),
        .ADDR_W       (ADDR_W),
        .PRIME_FRAMES (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_reset (sys_reset),
        .restart   (restart),
        .strm      (bus.slave),
        .rom_addr  (rom_addr),
        .weight1   (weight1),
        .weight2   (weight2),
        .weight3   (weight3),
        .primed    (primed),
        .sync_err  (sync_err)
    );

    always #5 sys_clk = ~sys_clk;

    // Registered weight ROM, one-cycle read latency.
    logic [2:0] rom1 [0:1023];
    logic [2:0] rom2 [0:1023];
    logic [2:0] rom3 [0:1023];
    always @(posedge sys_clk) begin
        weight1 <= rom1[rom_addr];
        weight2 <= rom2[rom_addr];
        weight3 <= rom3[rom_addr];
    end

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] sym;
        logic       last;
        int         stamp;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the decoder should have emitted at each position
    // in each of the last three frames.
    logic [3:0] h1 [FL];
    logic [3:0] h2 [FL];
    logic [3:0] h3 [FL];
    int         m_pos;
    int         m_frames;

    // Monitor: every output pulse must match the oldest pending expectation, 2 cycles after issue.
    always @(negedge sys_clk) begin
        if (sys_reset && bus.out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got sym=%0d last=%0b want no output", bus.out_symbol, bus.out_last);
            end else begin
                mon_e = q.pop_front();
                if (bus.out_symbol !== mon_e.sym || bus.out_last !== mon_e.last || (cyc - mon_e.stamp) != 2) begin
                    errors++;
                    $display("FAIL out_sample got sym=%0d last=%0b lat=%0d want sym=%0d last=%0b lat=2",
                             bus.out_symbol, bus.out_last, cyc - mon_e.stamp, mon_e.sym, mon_e.last);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [3:0] model_pred(input int p);
        int s;
        s = rom1[p] * h1[p] + rom2[p] * h2[p] + rom3[p] * h3[p];
        return 4'((s / 10) % 16);
    endfunction

    task automatic model_clear();
        m_pos    = 0;
        m_frames = 0;
        q.delete();
    endtask

    task automatic set_rom(input bit rnd, input logic [2:0] val);
        for (int i = 0; i < 1024; i++) begin
            rom1[i] = rnd ? 3'($urandom) : val;
            rom2[i] = rnd ? 3'($urandom) : val;
            rom3[i] = rnd ? 3'($urandom) : val;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.in_valid  = 1'b0;
            bus.in_symbol = 4'($urandom);
            bus.in_last   = 1'($urandom);
            @(posedge sys_clk);
            #1;
        end
        bus.in_last = 1'b0;
    endtask

    // Present one symbol for one accept, then advance the model.
    task automatic issue(input logic [3:0] sym, input logic [3:0] expv, input logic lst, input bit push_it);
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.in_symbol = sym;
        bus.in_last   = lst;
        e.sym   = expv;
        e.last  = (m_pos == FL - 1);
        e.stamp = cyc;
        @(posedge sys_clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (push_it) q.push_back(e);
        h3[m_pos] = h2[m_pos];
        h2[m_pos] = h1[m_pos];
        h1[m_pos] = expv;
        if (m_pos == FL - 1) begin
            if (m_frames < 3) m_frames++;
            m_pos = 0;
        end else if (lst) begin
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    // Encode an original sample (raw while priming) and expect it back.
    task automatic send_orig(input logic [3:0] o, input logic lst);
        if (m_frames < 3) issue(o, o, lst, 1'b1);
        else              issue(4'(o - model_pred(m_pos)), o, lst, 1'b1);
    endtask

    task automatic send_res(input logic [3:0] res, input logic [3:0] expv);
        issue(res, expv, (m_pos == FL - 1), 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge sys_clk);
        #1;
        chk("drain_pending", 32'(q.size()), 32'd0);
    endtask

    task automatic do_restart(input logic with_valid);
        restart       = 1'b1;
        bus.in_valid  = with_valid;
        bus.in_symbol = 4'($urandom);
        bus.in_last   = 1'b0;
        @(posedge sys_clk);
        #1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
        chk("restart_out_valid", 32'(bus.out_valid), 32'd0);
        chk("restart_primed", 32'(primed), 32'd0);
        chk("restart_sync_err", 32'(sync_err), 32'd0);
        chk("restart_rom_addr", 32'(rom_addr), 32'd0);
    endtask

    task automatic prime_frames(input bit rnd, input logic [3:0] val);
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < FL; p++)
                send_orig(rnd ? 4'($urandom) : val, (p == FL - 1));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_symbol = '0;
        bus.in_last   = 1'b0;
        restart       = 1'b0;
        sys_reset     = 1'b1;
        set_rom(1'b0, 3'd0);
        model_clear();
        #1 sys_reset = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_symbol", 32'(bus.out_symbol), 32'd0);
        chk("reset_out_last", 32'(bus.out_last), 32'd0);
        chk("reset_primed", 32'(primed), 32'd0);
        chk("reset_sync_err", 32'(sync_err), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr), 32'd0);
        repeat (3) @(posedge sys_clk);
        #1 sys_reset = 1'b1;
        idle(2);

        // Priming pass-through with in_symbol = pos mod 16.
        set_rom(1'b1, 3'd0);
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < FL; p++) begin
                if (f == 2 && p == FL - 1) chk("primed_before_last", 32'(primed), 32'd0);
                send_orig(4'(p), (p == FL - 1));
            end
        end
        chk("primed_after_288", 32'(primed), 32'd1);
        drain();

        // One decoded symbol in flight, then restart together with in_valid.
        issue(4'($urandom), 4'd0, 1'b0, 1'b0);
        do_restart(1'b1);
        idle(3);

        // Basic decode: history 5, weights 3 -> pred 4, residual 2 -> 6.
        set_rom(1'b0, 3'd3);
        idle(1);
        prime_frames(1'b0, 4'd5);
        chk("primed_basic", 32'(primed), 32'd1);
        for (int p = 0; p < FL; p++) send_res(4'd2, 4'd6);
        drain();
        do_restart(1'b0);

        // Wrap: history 15, weights 7 -> sum 315, pred 31 -> F, residual 3 -> 2.
        set_rom(1'b0, 3'd7);
        idle(1);
        prime_frames(1'b0, 4'd15);
        for (int p = 0; p < FL; p++) send_res(4'd3, 4'd2);
        drain();
        do_restart(1'b0);

        // Round trip over 10 frames with random weights, samples and gaps.
        set_rom(1'b1, 3'd0);
        idle(1);
        for (int f = 0; f < 10; f++) begin
            for (int p = 0; p < FL; p++) begin
                send_orig(4'($urandom), (p == FL - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
        chk("primed_roundtrip", 32'(primed), 32'd1);

        // Frame sync: early in_last at position 50.
        for (int p = 0; p <= 50; p++) send_orig(4'($urandom), (p == 50));
        chk("sync_err_set", 32'(sync_err), 32'd1);
        chk("rom_addr_resync", 32'(rom_addr), 32'd0);
        for (int p = 0; p < FL; p++) send_orig(4'($urandom), (p == FL - 1));
        drain();
        chk("sync_err_sticky", 32'(sync_err), 32'd1);
        do_restart(1'b0);

        // Async reset mid-frame while decoding.
        prime_frames(1'b1, 4'd0);
        for (int p = 0; p < 10; p++) send_orig(4'($urandom), 1'b0);
        chk("out_valid_before_reset", 32'(bus.out_valid), 32'd1);
        #2 sys_reset = 1'b0;
        #1;
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_out_symbol", 32'(bus.out_symbol), 32'd0);
        chk("midreset_out_last", 32'(bus.out_last), 32'd0);
        chk("midreset_primed", 32'(primed), 32'd0);
        model_clear();
        @(posedge sys_clk);
        #1 sys_reset = 1'b1;
        idle(2);
        chk("no_stale_output", 32'(q.size()), 32'd0);

        // Full re-prime then one decoded frame.
        prime_frames(1'b1, 4'd0);
        chk("primed_after_reprime", 32'(primed), 32'd1);
        for (int p = 0; p < FL; p++) send_orig(4'($urandom), (p == FL - 1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lnn_decoder.md
Name: lnn_decoder

Overview:
- Receiver-side inverse of the linear-prediction residual encoder.
- Accepts a stream of 4-bit residual symbols organised as frames of FRAME_LEN positions.
- Rebuilds original 4-bit samples as: residual + prediction, where prediction = (w1*p1 + w2*p2 + w3*p3)/10. p1/p2/p3 are the samples at the same position in the previous three frames; w1..w3 come from the shared weight ROM.
- The first three frames carry raw samples (priming): passed through unchanged and used only to fill the history.

Parameters:
FRAME_LEN, 96, samples per frame (>=2)
ADDR_W, 10, weight ROM address width
PRIME_FRAMES, 3, raw frames before decoding starts (fixed by the 3-tap predictor; do not change)

Ports:
sys_clk  in  1  clock, rising edge
sys_reset  in  1  asynchronous, active-low reset
restart  in  1  synchronous restart to priming (pulse)
in_valid  in  1  in_symbol/in_last valid this cycle; gaps allowed
in_symbol  in  4  raw sample (priming) or residual (decoding)
in_last  in  1  marks final position of a frame
rom_addr  out  ADDR_W  weight ROM address; combinational from position counter
weight1  in  3  ROM tap for p1; registered ROM, 1-cycle read latency
weight2  in  3  ROM tap for p2
weight3  in  3  ROM tap for p3
out_valid  out  1  one-cycle pulse per reconstructed sample; no backpressure
out_symbol  out  4  reconstructed sample
out_last  out  1  out_valid for position FRAME_LEN-1
primed  out  1  high once PRIME_FRAMES frames have been accepted
sync_err  out  1  sticky; in_last/position mismatch seen

Behaviour:
- Reset (async, active-low) values:
  - out_valid=0, out_symbol=0, out_last=0, primed=0, sync_err=0.
  - Position counter pos=0, frame counter=0, state=PRIME, stage-1 valid=0.
  - History RAMs are not cleared; priming overwrites them.
- States:
  - PRIME: output = in_symbol.
  - DECODE: output = (in_symbol + pred[3:0]) mod 16.
  - PRIME->DECODE on acceptance of position FRAME_LEN-1 of frame PRIME_FRAMES-1. primed rises the same edge.
  - DECODE has no exit except reset or restart.
- Acceptance:
  - A symbol is accepted every cycle in_valid=1; there is no in_ready.
  - rom_addr=pos.
  - Acceptance edge t: symbol, pos and last are captured into stage 1; pos increments, wrapping FRAME_LEN-1 -> 0.
  - The frame counter increments on wrap and saturates at PRIME_FRAMES.
- Stage 1 (cycle t+1): weights are valid for the captured position.
  - sum = w1*p1 + w2*p2 + w3*p3, 9-bit unsigned (max 315).
  - pred = floor(sum/10) (max 31), truncated to 4 bits.
  - Result registered at edge t+1, so out_valid is high during cycle t+2. Latency 2, throughput 1/cycle.
- History update, same edge as the output register, for position k:
  - p3[k] <= p2[k]; p2[k] <= p1[k]; p1[k] <= out value.
  - Applies in both PRIME and DECODE.
  - Consecutive accepts target different k (FRAME_LEN>=2), so there is no read-after-write hazard.
- Arithmetic: all modulo 16. This exactly inverses the encoder's wrapped subtraction, making the scheme lossless.
- Frame sync:
  - in_last=1 with pos!=FRAME_LEN-1: sync_err<=1; symbol is still processed; pos forced to 0 next.
  - in_last=0 at pos=FRAME_LEN-1: sync_err<=1; pos wraps normally.
  - sync_err clears only on reset or restart.
- restart:
  - Returns state to PRIME: pos=0, frame count=0, primed=0, sync_err=0.
  - Clears stage-1 valid so no in-flight output is emitted (out_valid=0 next cycle).
  - restart and in_valid in the same cycle: restart wins; the symbol is dropped.
- Reset mid-frame: in-flight sample lost; decoding resumes only after full re-priming.

Decomposition:
- Shared package (lnn_pkg): FRAME_LEN, SYMBOL_W=4, WEIGHT_W=3, DIVISOR=10, PRIME_FRAMES=3, state encoding. The encoder uses the same package.
- One natural sub-module: lnn_predict, combinational.
  - Inputs: w1..w3, p1..p3.
  - Output: 4-bit pred.
  - Reused by the encoder so both sides compute bit-identical predictions.
- The weight ROM is instantiated outside, at the top level.

Test Plan:
- Priming pass-through: 3 frames with in_symbol = pos mod 16 -> out_symbol identical, latency 2; out_last on each position 95; primed rises after the 288th accept.
- Basic decode: history all 5, weights 3/3/3, residual 2 -> sum 45, pred 4, out_symbol 6.
- Wrap: history all 15, weights 7/7/7, residual 3 -> sum 315, pred 31 -> 4'hF; out_symbol 2.
- Round-trip: random samples through the reference encoder model, then this block (with in_valid gaps) over 10 frames -> output equals original samples bit-exact.
- Sync error: in_last at pos 50 -> sync_err=1; next accepted symbol uses rom_addr 0; sync_err stays high until restart.
- Reset/restart: async reset mid-frame during DECODE -> all outputs 0 immediately. restart together with in_valid -> symbol dropped, primed=0, next 3 frames pass through raw.
